alu_mc: RTL and testbench

- Parametrised multi-cycle execute unit, the next generation of the single-cycle ALU.
- Executes the base RV32I ALU ops plus the RV32M mul/div/rem ops behind a valid/ready handshake.
- Sits in the EX stage; the pipeline stalls while in_ready or out_valid is low.
- Base ops complete in one cycle. MUL and DIV families run iteratively, one bit per cycle.

---
 rtl/alu_mc_pkg.sv | 56 +++++
 rtl/alu_mc_iter.sv | 85 ++++++++
 rtl/alu_mc.sv | 218 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle execute unit: op codes, select
// layout and FSM state encoding.
package alu_mc_pkg;

  // Bit of sel that switches between base ALU ops and the M extension.
  localparam int SEL_M = 4;

  // Base ALU codes carried in sel[3:0] when sel[SEL_M] == 0.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // M-extension funct3 codes carried in sel[2:0] when sel[SEL_M] == 1.
  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_op_e;

  // Execute-unit FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // funct3[2] set: divide family; funct3[1] set: remainder; funct3[0] clear: signed divide.
  function automatic logic m_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic m_is_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

  function automatic logic m_div_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath shared by multiply and divide. Works on unsigned
// magnitudes; sign fix-up is done by the caller once done is seen.
// acc layout: multiply -> full product {hi, lo}; divide -> {remainder, quotient}.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              done,
  output logic [2*XLEN-1:0] acc
);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;

  // One multiplier bit (shift-add) or one quotient bit (restoring) per cycle.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = shifted - {1'b0, opb_q};
    if (flush) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(XLEN);
      div_d  = is_div;
      opb_d  = op_b;
      acc_d  = {{XLEN{1'b0}}, op_a};
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        // Result is held in acc until the next start.
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (div_q) begin
          if (diff[XLEN]) acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          else            acc_d = {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[XLEN-1:1]};
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      opb_q  <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      opb_q  <= opb_d;
      acc_q  <= acc_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign acc  = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage execute unit: single-cycle base ALU ops plus
// iterative RV32M multiply/divide behind a valid/ready handshake.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      sel,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt_signed,
  output logic            lt_unsigned
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            lts_q, lts_d;
  logic            ltu_q, ltu_d;
  logic [2:0]      f3_q, f3_d;
  logic            negp_q, negp_d;
  logic            negr_q, negr_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic            lt_s, lt_u;
  logic [XLEN-1:0] base_res;
  logic [2:0]      f3;
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, ovf;
  logic            load;
  logic [XLEN-1:0] res_new;
  logic [XLEN-1:0] fix_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  logic              iter_start;
  logic              iter_done;
  logic [2*XLEN-1:0] iter_acc;

  assign lt_s = $signed(A) < $signed(B);
  assign lt_u = A < B;
  assign f3   = sel[2:0];

  // Single-cycle base ALU; unknown codes yield zero.
  always_comb begin
    base_res = '0;
    case (sel[3:0])
      ALU_ADD:  base_res = A + B;
      ALU_SUB:  base_res = A - B;
      ALU_SLL:  base_res = A << B[SH_W-1:0];
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  base_res = A ^ B;
      ALU_SRL:  base_res = A >> B[SH_W-1:0];
      ALU_SRA:  base_res = $signed(A) >>> B[SH_W-1:0];
      ALU_OR:   base_res = A | B;
      ALU_AND:  base_res = A & B;
      default:  base_res = '0;
    endcase
  end

  // Operand conditioning for the iterator: signedness per op, magnitudes, special cases.
  always_comb begin
    if (m_is_div(f3)) begin
      a_sgn = m_div_signed(f3);
      b_sgn = m_div_signed(f3);
    end else begin
      a_sgn = (f3 == M_MULH) || (f3 == M_MULHSU);
      b_sgn = (f3 == M_MULH);
    end
    sa     = a_sgn & A[XLEN-1];
    sb     = b_sgn & B[XLEN-1];
    a_mag  = sa ? -A : A;
    b_mag  = sb ? -B : B;
    b_zero = (B == '0);
    ovf    = m_div_signed(f3) && (A == MOST_NEG) && (B == '1);
  end

  // Sign fix-up and half/quotient/remainder selection once iteration ends.
  always_comb begin
    prod = negp_q ? -iter_acc : iter_acc;
    quo  = negp_q ? -iter_acc[XLEN-1:0] : iter_acc[XLEN-1:0];
    rem  = negr_q ? -iter_acc[2*XLEN-1:XLEN] : iter_acc[2*XLEN-1:XLEN];
    if (m_is_div(f3_q))       fix_res = m_is_rem(f3_q) ? rem : quo;
    else if (f3_q == M_MUL)   fix_res = prod[XLEN-1:0];
    else                      fix_res = prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush overrides every transition but keeps result and flags.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    lts_d      = lts_q;
    ltu_d      = ltu_q;
    f3_d       = f3_q;
    negp_d     = negp_q;
    negr_d     = negr_q;
    iter_start = 1'b0;
    load       = 1'b0;
    res_new    = '0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            lts_d  = lt_s;
            ltu_d  = lt_u;
            f3_d   = f3;
            negp_d = sa ^ sb;
            negr_d = sa;
            if (!sel[SEL_M]) begin
              load    = 1'b1;
              res_new = base_res;
              state_d = ST_DONE;
            end else if (m_is_div(f3) && b_zero) begin
              load    = 1'b1;
              res_new = m_is_rem(f3) ? A : '1;
              state_d = ST_DONE;
            end else if (m_is_div(f3) && ovf) begin
              load    = 1'b1;
              res_new = m_is_rem(f3) ? '0 : A;
              state_d = ST_DONE;
            end else begin
              iter_start = 1'b1;
              state_d    = m_is_div(f3) ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_done) state_d = ST_FIX;
        end
        ST_FIX: begin
          load    = 1'b1;
          res_new = fix_res;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (load) begin
      result_d = res_new;
      zero_d   = (res_new == '0);
    end
  end

  assign out_valid_d = (state_d == ST_DONE);
  assign in_ready_d  = (state_d == ST_IDLE);

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      lts_q       <= 1'b0;
      ltu_q       <= 1'b0;
      f3_q        <= '0;
      negp_q      <= 1'b0;
      negr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      lts_q       <= lts_d;
      ltu_q       <= ltu_d;
      f3_q        <= f3_d;
      negp_q      <= negp_d;
      negr_q      <= negr_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  alu_mc_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (iter_start),
    .is_div (m_is_div(f3)),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .done   (iter_done),
    .acc    (iter_acc)
  );

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign lt_signed   = lts_q;
  assign lt_unsigned = ltu_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed and swept checks of alu_mc (XLEN = 32) against hand values and
// an arithmetic reference model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  sel = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_ready, out_valid, zero, lt_signed, lt_unsigned;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  logic [31:0] r_res;
  logic        r_zero, r_lts, r_ltu;
  int          r_edges;

  localparam int ITER_LAT = 34;

  alu_mc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .lt_signed   (lt_signed),
    .lt_unsigned (lt_unsigned)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op, wait for out_valid (bounded), hold for stall cycles, then hand off.
  task automatic run_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b, input int stall);
    int n;
    @(negedge clk);
    sel = s; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; sel = 5'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    r_edges = n; r_res = result; r_zero = zero; r_lts = lt_signed; r_ltu = lt_unsigned;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold", {out_valid, in_ready, zero, lt_signed, lt_unsigned, result},
                  {1'b1, 1'b0, r_zero, r_lts, r_ltu, r_res});
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("handoff", {out_valid, in_ready}, 2'b01);
  endtask

  function automatic logic [31:0] ref_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, pr;
    logic [63:0] ua, ub, ur;
    logic signed [31:0] sa, sb, sq;
    sa = a; sb = b;
    ua = {32'b0, a}; ub = {32'b0, b};
    if (!s[4]) begin
      case (s[3:0])
        4'd0: return a + b;
        4'd1: return a - b;
        4'd2: return a << b[4:0];
        4'd3: return (sa < sb) ? 32'd1 : 32'd0;
        4'd4: return (a < b) ? 32'd1 : 32'd0;
        4'd5: return a ^ b;
        4'd6: return a >> b[4:0];
        4'd7: return sa >>> b[4:0];
        4'd8: return a | b;
        4'd9: return a & b;
        default: return 32'd0;
      endcase
    end
    case (s[2:0])
      3'd0: begin ur = ua * ub; return ur[31:0]; end
      3'd1: begin pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; pr = pa * pb; return pr[63:32]; end
      3'd2: begin pa = {{32{a[31]}}, a}; pb = {32'b0, b}; pr = pa * pb; return pr[63:32]; end
      3'd3: begin ur = ua * ub; return ur[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  s;
    logic [31:0] a, b, exp_r;
    int          exp_lat, seen;
    logic        special;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {in_ready, out_valid, zero, lt_signed, lt_unsigned, result},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk); rst_n = 1'b1;

    // Base ops
    run_op({1'b0, ALU_ADD}, 32'd7, 32'd5, 3);
    chk("add lat", r_edges, 0);
    chk("add res", {r_zero, r_lts, r_ltu, r_res}, {1'b0, 1'b0, 1'b0, 32'd12});
    run_op({1'b0, ALU_SLT}, 32'hFFFF_FFFF, 32'd1, 0);
    chk("slt", {r_lts, r_ltu, r_res}, {1'b1, 1'b0, 32'd1});
    run_op({1'b0, ALU_SUB}, 32'd5, 32'd5, 0);
    chk("sub zero", {r_zero, r_res}, {1'b1, 32'd0});
    run_op({1'b0, ALU_SRA}, 32'h8000_0000, 32'h24, 1);
    chk("sra", r_res, 32'hF800_0000);
    run_op(5'b01111, 32'd3, 32'd4, 0);
    chk("unknown base", r_res, 32'd0);

    // Multiply family
    run_op({2'b10, M_MULH}, 32'hFFFF_FFFF, 32'd2, 2);
    chk("mulh lat", r_edges, ITER_LAT);
    chk("mulh", r_res, 32'hFFFF_FFFF);
    run_op({2'b10, M_MULHU}, 32'hFFFF_FFFF, 32'd2, 0);
    chk("mulhu", r_res, 32'h0000_0001);
    run_op({2'b10, M_MUL}, 32'hFFFF_FFFF, 32'd2, 0);
    chk("mul", r_res, 32'hFFFF_FFFE);

    // Divide family
    run_op({2'b10, M_DIV}, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div lat", r_edges, ITER_LAT);
    chk("div", r_res, 32'hFFFF_FFFD);
    run_op({2'b10, M_REM}, 32'hFFFF_FFF9, 32'd2, 0);
    chk("rem", r_res, 32'hFFFF_FFFF);
    run_op({2'b10, M_DIVU}, 32'd100, 32'd7, 0);
    chk("divu", r_res, 32'd14);

    // Special cases
    run_op({2'b10, M_DIV}, 32'd5, 32'd0, 0);
    chk("div0", {r_edges, r_res}, {32'd0, 32'hFFFF_FFFF});
    run_op({2'b10, M_REMU}, 32'd5, 32'd0, 0);
    chk("remu0", {r_edges, r_res}, {32'd0, 32'd5});
    run_op({2'b10, M_DIV}, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div ovf", {r_edges, r_res}, {32'd0, 32'h8000_0000});
    run_op({2'b10, M_REM}, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("rem ovf", {r_zero, r_res}, {1'b1, 32'd0});

    // Flush mid-iteration keeps the previous result
    run_op({1'b0, ALU_ADD}, 32'd3, 32'd4, 0);
    @(negedge clk); sel = {2'b10, M_DIVU}; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush", {in_ready, out_valid, result}, {1'b1, 1'b0, 32'd7});
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("flush no valid", seen, 0);

    // Flush together with in_valid in IDLE: not accepted
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; sel = {1'b0, ALU_ADD}; A = 32'd1; B = 32'd1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush blocks accept", {in_ready, out_valid, result}, {1'b1, 1'b0, 32'd7});

    // Asynchronous reset mid-iteration
    @(negedge clk); sel = {2'b10, M_DIVU}; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("async reset", {in_ready, out_valid, zero, lt_signed, lt_unsigned, result},
                       {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk); rst_n = 1'b1;
    run_op({2'b10, M_DIVU}, 32'd100, 32'd7, 0);
    chk("after reset", {r_edges, r_res}, {32'd34, 32'd14});

    // Swept ops versus the reference model with random stalls
    for (int k = 0; k < 1000; k++) begin
      s = 5'($urandom);
      a = pick_operand();
      b = pick_operand();
      special = s[4] && s[2] && ((b == 0) || (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      exp_lat = (!s[4] || special) ? 0 : ITER_LAT;
      exp_r = ref_op(s, a, b);
      run_op(s, a, b, $urandom_range(0, 3));
      chk($sformatf("sweep %0d sel=%0h a=%0h b=%0h", k, s, a, b),
          {r_edges, r_zero, r_lts, r_ltu, r_res},
          {exp_lat, (exp_r == 0), ($signed(a) < $signed(b)), (a < b), exp_r});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
